mem_traffic_gen: RTL and testbench

Parametrised, self-checking traffic generator for the main memory's ray-tracer (RT) ports. It drives NUM_CH independent RT channels with sequential write and read bursts and honours the shared ready handshake. It optionally compares read-back data against the written pattern. It sits between the bring-up top level and mem_main, replacing free-running toggled enables with programmable, repeatable bursts.

---
 rtl/mem_tg_pkg.sv | 31 +++
 rtl/mem_tg_checker.sv | 53 +++++
 rtl/mem_traffic_gen.sv | 173 +++++++++++++++++
 tb/tb_mem_traffic_gen.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_tg_pkg.sv
// mem_tg_pkg: shared types and helpers for the memory traffic generator.
//   mode_t          - run mode (write-only, read-only, write-then-read, alternate)
//   state_t         - controller state encoding
//   DEF_PATTERN_KEY - default XOR key for the data pattern
//   mem_tg_pattern  - address -> expected data (addr ^ key), up to 64 bits wide
package mem_tg_pkg;

    typedef enum logic [1:0] {
        MODE_WR    = 2'd0,
        MODE_RD    = 2'd1,
        MODE_WR_RD = 2'd2,
        MODE_ALT   = 2'd3
    } mode_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WR   = 2'd1,
        ST_RD   = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    localparam logic [31:0] DEF_PATTERN_KEY = 32'hA5A5_A5A5;

    // Callers zero-extend the address and key to 64 bits and truncate the
    // result to their data width.
    function automatic logic [63:0] mem_tg_pattern(input logic [63:0] addr,
                                                   input logic [63:0] key);
        return addr ^ key;
    endfunction

endpackage

// File: rtl/mem_tg_checker.sv
// mem_tg_checker: read-back comparator for the traffic generator.
//   clk, rst_n   - clock, async active-low reset
//   i_clear      - clears err/err_cnt (a run is starting)
//   i_valid      - an accepted read is on the bus this cycle
//   i_rdata      - NUM_CH x DATA_W read data
//   i_exp        - NUM_CH x DATA_W expected data
//   o_err        - sticky mismatch flag
//   o_err_cnt    - saturating mismatch count, at most +1 per cycle
module mem_tg_checker #(
    parameter int NUM_CH = 4,
    parameter int DATA_W = 32
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     i_clear,
    input  logic                     i_valid,
    input  logic [NUM_CH*DATA_W-1:0] i_rdata,
    input  logic [NUM_CH*DATA_W-1:0] i_exp,
    output logic                     o_err,
    output logic [15:0]              o_err_cnt
);

    logic [NUM_CH-1:0] w_mis;
    logic              w_any_mis;
    logic              r_err;
    logic [15:0]       r_err_cnt;

    for (genvar c = 0; c < NUM_CH; c++) begin : g_cmp
        assign w_mis[c] = (i_rdata[c*DATA_W +: DATA_W] != i_exp[c*DATA_W +: DATA_W]);
    end

    // Any number of failing channels in one cycle counts as one mismatch.
    assign w_any_mis = i_valid && (|w_mis);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err     <= 1'b0;
            r_err_cnt <= '0;
        end else if (i_clear) begin
            r_err     <= 1'b0;
            r_err_cnt <= '0;
        end else if (w_any_mis) begin
            r_err <= 1'b1;
            if (r_err_cnt != 16'hFFFF) begin
                r_err_cnt <= r_err_cnt + 16'd1;
            end
        end
    end

    assign o_err     = r_err;
    assign o_err_cnt = r_err_cnt;

endmodule

// File: rtl/mem_traffic_gen.sv
// mem_traffic_gen: burst traffic generator for NUM_CH ray-tracer memory ports.
// Build option: MEM_TG_CHECK_EN adds the read-back checker; without it
// err/err_cnt are tied to 0 and mem_rdata is ignored.
//   clk, rst_n       - clock, async active-low reset
//   i_start          - begin a run (sampled in IDLE only)
//   i_mode           - mode_t, latched on start
//   i_base_addr      - run base address, latched on start
//   i_len            - words per channel, latched on start
//   o_busy           - high in WR/RD
//   o_done           - one-cycle pulse after the last accepted access
//   o_mem_we/o_mem_re- per-channel write/read requests
//   o_mem_addr       - per-channel address base + c*len + i
//   o_mem_wdata      - per-channel write data addr ^ PATTERN_KEY
//   i_mem_rdata      - per-channel read data, valid with i_mem_rdy
//   i_mem_rdy        - shared ready, accepts all channels at once
//   o_err, o_err_cnt - checker results
module mem_traffic_gen
    import mem_tg_pkg::*;
#(
    parameter int          NUM_CH      = 4,
    parameter int          ADDR_W      = 32,
    parameter int          DATA_W      = 32,
    parameter int          LEN_W       = 16,
    parameter logic [31:0] PATTERN_KEY = DEF_PATTERN_KEY
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     i_start,
    input  logic [1:0]               i_mode,
    input  logic [ADDR_W-1:0]        i_base_addr,
    input  logic [LEN_W-1:0]         i_len,
    output logic                     o_busy,
    output logic                     o_done,
    output logic [NUM_CH-1:0]        o_mem_we,
    output logic [NUM_CH-1:0]        o_mem_re,
    output logic [NUM_CH*ADDR_W-1:0] o_mem_addr,
    output logic [NUM_CH*DATA_W-1:0] o_mem_wdata,
    input  logic [NUM_CH*DATA_W-1:0] i_mem_rdata,
    input  logic                     i_mem_rdy,
    output logic                     o_err,
    output logic [15:0]              o_err_cnt
);

    state_t             r_state;
    state_t             w_state_nxt;
    mode_t              r_mode;
    logic [ADDR_W-1:0]  r_base;
    logic [LEN_W-1:0]   r_len;
    logic [LEN_W-1:0]   r_idx;
    logic [LEN_W-1:0]   w_idx_nxt;
    logic               w_start_acc;
    logic               w_last;
    logic               w_wr;
    logic               w_rd;
    logic [NUM_CH*DATA_W-1:0] w_exp;

    assign w_start_acc = (r_state == ST_IDLE) && i_start;
    assign w_last      = (r_idx == (r_len - LEN_W'(1)));
    assign w_wr        = (r_state == ST_WR);
    assign w_rd        = (r_state == ST_RD);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_mode  <= MODE_WR;
            r_base  <= '0;
            r_len   <= '0;
            r_idx   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_idx   <= w_idx_nxt;
            if (w_start_acc) begin
                r_mode <= mode_t'(i_mode);
                r_base <= i_base_addr;
                r_len  <= i_len;
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        case (r_state)
            ST_IDLE: begin
                if (i_start) begin
                    w_idx_nxt = '0;
                    if (i_len == '0) begin
                        w_state_nxt = ST_DONE;
                    end else if (mode_t'(i_mode) == MODE_RD) begin
                        w_state_nxt = ST_RD;
                    end else begin
                        w_state_nxt = ST_WR;
                    end
                end
            end
            ST_WR: begin
                if (i_mem_rdy) begin
                    case (r_mode)
                        // Alternate mode reads back the same word before advancing.
                        MODE_ALT: w_state_nxt = ST_RD;
                        MODE_WR_RD: begin
                            if (w_last) begin
                                w_state_nxt = ST_RD;
                                w_idx_nxt   = '0;
                            end else begin
                                w_idx_nxt = r_idx + LEN_W'(1);
                            end
                        end
                        default: begin
                            if (w_last) begin
                                w_state_nxt = ST_DONE;
                            end else begin
                                w_idx_nxt = r_idx + LEN_W'(1);
                            end
                        end
                    endcase
                end
            end
            ST_RD: begin
                if (i_mem_rdy) begin
                    if (w_last) begin
                        w_state_nxt = ST_DONE;
                    end else begin
                        w_idx_nxt = r_idx + LEN_W'(1);
                        if (r_mode == MODE_ALT) begin
                            w_state_nxt = ST_WR;
                        end
                    end
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    assign o_busy   = w_wr || w_rd;
    assign o_done   = (r_state == ST_DONE);
    assign o_mem_we = {NUM_CH{w_wr}};
    assign o_mem_re = {NUM_CH{w_rd}};

    // Address/data are pure functions of the latched run and index, so they
    // stay stable until the index moves on an accepted access. They are
    // gated to 0 outside an active request so reset forces them to 0.
    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        logic [ADDR_W-1:0] w_addr;
        assign w_addr = r_base + (ADDR_W'(c) * ADDR_W'(r_len)) + ADDR_W'(r_idx);
        assign w_exp[c*DATA_W +: DATA_W] =
            DATA_W'(mem_tg_pattern(64'(w_addr), 64'(PATTERN_KEY)));
        assign o_mem_addr[c*ADDR_W +: ADDR_W]  = o_busy ? w_addr : '0;
        assign o_mem_wdata[c*DATA_W +: DATA_W] = w_wr ? w_exp[c*DATA_W +: DATA_W] : '0;
    end

`ifdef MEM_TG_CHECK_EN
    mem_tg_checker #(
        .NUM_CH (NUM_CH),
        .DATA_W (DATA_W)
    ) u_checker (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_clear   (w_start_acc),
        .i_valid   (w_rd && i_mem_rdy),
        .i_rdata   (i_mem_rdata),
        .i_exp     (w_exp),
        .o_err     (o_err),
        .o_err_cnt (o_err_cnt)
    );
`else
    logic w_unused_rdata;
    assign w_unused_rdata = ^i_mem_rdata;
    assign o_err          = 1'b0;
    assign o_err_cnt      = '0;
`endif

endmodule

// File: tb/tb_mem_traffic_gen.sv
`timescale 1ns/1ps
module tb_mem_traffic_gen;

    localparam int          NUM_CH = 4;
    localparam int          AW     = 32;
    localparam int          DW     = 32;
    localparam int          LW     = 16;
    localparam logic [31:0] KEY    = 32'hA5A5_A5A5;
`ifdef MEM_TG_CHECK_EN
    localparam bit CHECK_EN = 1'b1;
`else
    localparam bit CHECK_EN = 1'b0;
`endif

    logic                  clk = 1'b0;
    logic                  rst_n = 1'b0;
    logic                  i_start = 1'b0;
    logic [1:0]            i_mode = 2'd0;
    logic [AW-1:0]         i_base_addr = '0;
    logic [LW-1:0]         i_len = '0;
    logic                  o_busy, o_done;
    logic [NUM_CH-1:0]     o_mem_we, o_mem_re;
    logic [NUM_CH*AW-1:0]  o_mem_addr;
    logic [NUM_CH*DW-1:0]  o_mem_wdata;
    logic [NUM_CH*DW-1:0]  i_mem_rdata;
    logic                  i_mem_rdy = 1'b0;
    logic                  o_err;
    logic [15:0]           o_err_cnt;

    int n_chk = 0;
    int n_err = 0;
    int bad_left = 0;

    mem_traffic_gen #(
        .NUM_CH (NUM_CH), .ADDR_W (AW), .DATA_W (DW), .LEN_W (LW), .PATTERN_KEY (KEY)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_start     (i_start),
        .i_mode      (i_mode),
        .i_base_addr (i_base_addr),
        .i_len       (i_len),
        .o_busy      (o_busy),
        .o_done      (o_done),
        .o_mem_we    (o_mem_we),
        .o_mem_re    (o_mem_re),
        .o_mem_addr  (o_mem_addr),
        .o_mem_wdata (o_mem_wdata),
        .i_mem_rdata (i_mem_rdata),
        .i_mem_rdy   (i_mem_rdy),
        .o_err       (o_err),
        .o_err_cnt   (o_err_cnt)
    );

    always #5 clk = ~clk;

    // Memory model: returns the correct pattern, except channel 2 returns 0
    // while bad_left is nonzero.
    always_comb begin
        i_mem_rdata = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (c == 2 && bad_left > 0)
                i_mem_rdata[c*DW +: DW] = '0;
            else
                i_mem_rdata[c*DW +: DW] = o_mem_addr[c*AW +: AW] ^ KEY;
        end
    end

    typedef struct {
        logic                 is_wr;
        logic [NUM_CH*AW-1:0] addr;
        logic [NUM_CH*DW-1:0] wdata;
    } exp_t;
    exp_t q[$];

    typedef struct {
        logic [1:0]  mode;
        logic [31:0] base;
        int          len;
        int          rdy_kind;   // 0 always, 1 every other cycle, 2 random
        int          bad;        // reads with ch2 corrupted
        bit          poke;       // pulse start while busy
        int          exp_err;    // expected err_cnt with checker built
    } vec_t;
    vec_t vt[10];

    task automatic chk(input bit ok, input string name,
                       input logic [127:0] act, input logic [127:0] req);
        n_chk++;
        if (!ok) begin
            n_err++;
            $display("FAIL %s: got %0h required %0h at %0t", name, act, req, $time);
        end
    endtask

    task automatic push_acc(input bit wr, input logic [31:0] b, input int n, input int i);
        exp_t e;
        e.is_wr = wr;
        e.addr  = '0;
        e.wdata = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            logic [31:0] a;
            a = b + 32'(c * n) + 32'(i);
            e.addr[c*AW +: AW]  = a;
            e.wdata[c*DW +: DW] = a ^ KEY;
        end
        q.push_back(e);
    endtask

    task automatic push_run(input logic [1:0] m, input logic [31:0] b, input int n);
        case (m)
            2'd0: for (int i = 0; i < n; i++) push_acc(1'b1, b, n, i);
            2'd1: for (int i = 0; i < n; i++) push_acc(1'b0, b, n, i);
            2'd2: begin
                for (int i = 0; i < n; i++) push_acc(1'b1, b, n, i);
                for (int i = 0; i < n; i++) push_acc(1'b0, b, n, i);
            end
            default: for (int i = 0; i < n; i++) begin
                push_acc(1'b1, b, n, i);
                push_acc(1'b0, b, n, i);
            end
        endcase
    endtask

    // Called at posedge+1 in IDLE; returns at posedge+1 in IDLE after done.
    task automatic run_case(input vec_t v);
        int  acc = 0;
        int  busy_cyc = 0;
        int  cyc = 0;
        int  exp_a;
        bit  seen_done = 1'b0;
        bit  prev_acc;
        bit  acc_rd;
        bit  req;
        exp_t e;
        exp_a = (v.mode >= 2) ? 2 * v.len : v.len;
        q.delete();
        push_run(v.mode, v.base, v.len);
        bad_left    = v.bad;
        i_start     = 1'b1;
        i_mode      = v.mode;
        i_base_addr = v.base;
        i_len       = LW'(v.len);
        i_mem_rdy   = 1'b1;
        @(posedge clk); #1;
        i_start     = 1'b0;
        i_base_addr = 32'hBAD0_0000;
        i_len       = 16'd9;
        prev_acc    = 1'b1;
        while (!seen_done && cyc < 300) begin
            case (v.rdy_kind)
                0:       i_mem_rdy = 1'b1;
                1:       i_mem_rdy = cyc[0];
                default: i_mem_rdy = ($urandom_range(0, 1) == 1);
            endcase
            if (v.poke && cyc == 2) begin
                i_start = 1'b1; i_mode = 2'd2; i_base_addr = 32'hDEAD_0000;
            end else begin
                i_start = 1'b0;
            end
            @(negedge clk);
            acc_rd = 1'b0;
            if (cyc == 0)
                chk(o_busy == (v.len != 0), "busy_after_start", 128'(o_busy), 128'(v.len != 0));
            if (o_done) begin
                seen_done = 1'b1;
                chk(prev_acc && !o_busy && o_mem_we == '0 && o_mem_re == '0, "done_cycle",
                    {o_busy, o_mem_we, o_mem_re, 3'b0, prev_acc}, 128'h1);
                prev_acc = 1'b0;
            end else begin
                req = (o_mem_we != '0) || (o_mem_re != '0);
                if (o_busy)
                    chk((o_mem_we == '1 && o_mem_re == '0) || (o_mem_re == '1 && o_mem_we == '0),
                        "req_exclusive", {o_mem_we, o_mem_re}, 128'h0);
                else
                    chk(!req, "idle_no_req", {o_mem_we, o_mem_re}, 128'h0);
                if (o_busy) busy_cyc++;
                prev_acc = 1'b0;
                if (req) begin
                    if (q.size() == 0) begin
                        chk(1'b0, "extra_access", 128'(o_mem_addr), 128'h0);
                    end else begin
                        e = q[0];
                        chk((o_mem_we == '1) == e.is_wr && o_mem_addr == e.addr,
                            e.is_wr ? "wr_addr" : "rd_addr", o_mem_addr, e.addr);
                        if (e.is_wr)
                            chk(o_mem_wdata == e.wdata, "wr_data", o_mem_wdata, e.wdata);
                        if (i_mem_rdy) begin
                            void'(q.pop_front());
                            acc++;
                            prev_acc = 1'b1;
                            acc_rd   = !e.is_wr;
                        end
                    end
                end
            end
            @(posedge clk); #1;
            if (acc_rd && bad_left > 0) bad_left--;
            cyc++;
        end
        i_start = 1'b0;
        chk(seen_done, "done_timeout", 128'(cyc), 128'(exp_a));
        chk(acc == exp_a && q.size() == 0, "access_count", 128'(acc), 128'(exp_a));
        if (v.rdy_kind == 0)
            chk(busy_cyc == exp_a, "busy_cycles", 128'(busy_cyc), 128'(exp_a));
        chk(o_err == (CHECK_EN && v.exp_err > 0) &&
            o_err_cnt == (CHECK_EN ? 16'(v.exp_err) : 16'd0),
            "err_cnt", {o_err, o_err_cnt}, {(CHECK_EN && v.exp_err > 0), (CHECK_EN ? 16'(v.exp_err) : 16'd0)});
        chk(!o_done && !o_busy, "done_one_cycle", {o_done, o_busy}, 128'h0);
        bad_left = 0;
    endtask

    initial begin
        vec_t va;
        vt[0] = '{2'd2, 32'h0000_0100, 4, 0, 0, 1'b0, 0};
        vt[1] = '{2'd3, 32'h0000_0200, 2, 1, 0, 1'b0, 0};
        vt[2] = '{2'd1, 32'h0000_0300, 4, 0, 3, 1'b0, 3};
        vt[3] = '{2'd0, 32'h0000_0400, 0, 0, 0, 1'b0, 0};
        vt[4] = '{2'd2, 32'h0000_0400, 0, 0, 0, 1'b0, 0};
        vt[5] = '{2'd0, 32'hFFFF_FFFE, 4, 0, 0, 1'b1, 0};
        vt[6] = '{2'd1, 32'hFFFF_FFFE, 4, 0, 0, 1'b1, 0};
        vt[7] = '{2'd3, 32'h0000_0040, 3, 2, 0, 1'b0, 0};
        vt[8] = '{2'd2, 32'h0000_1000, 5, 2, 0, 1'b0, 0};
        vt[9] = '{2'd1, 32'h0000_2000, 3, 2, 1, 1'b0, 1};

        #2;
        chk(!o_busy && !o_done && o_mem_we == '0 && o_mem_re == '0 && o_mem_addr == '0 &&
            o_mem_wdata == '0 && !o_err && o_err_cnt == '0, "reset_state",
            {o_busy, o_done, o_mem_we, o_mem_re, o_err, o_err_cnt}, 128'h0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;

        for (int k = 0; k < 10; k++) run_case(vt[k]);

        // Abort mid-write at i=2, then a fresh run must begin at i=0.
        i_start = 1'b1; i_mode = 2'd0; i_base_addr = 32'h0000_0500; i_len = 16'd6; i_mem_rdy = 1'b1;
        @(posedge clk); #1;
        i_start = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk(o_mem_we == '1 && o_mem_addr[31:0] == 32'h0000_0502, "abort_pre_addr",
            128'(o_mem_addr[31:0]), 128'h502);
        rst_n = 1'b0;
        #1;
        chk(!o_busy && !o_done && o_mem_we == '0 && o_mem_re == '0 && o_mem_addr == '0 &&
            o_mem_wdata == '0 && !o_err && o_err_cnt == '0, "abort_outputs_zero",
            {o_busy, o_done, o_mem_we, o_mem_re, o_err, o_err_cnt}, 128'h0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk(!o_done && !o_busy, "abort_no_done", {o_done, o_busy}, 128'h0);
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
        va = '{2'd0, 32'h0000_0600, 3, 0, 0, 1'b0, 0};
        run_case(va);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
